// File: rtl/pn_stage_ctrl_pkg.sv
// Shared types, global timing defaults and helpers for the PN sort stage.
// WIDTH_TIME / MAX_TIME defaults are defined once here and reused by every file.
`ifndef WIDTH_TIME
`define WIDTH_TIME 8
`endif
`ifndef MAX_TIME
`define MAX_TIME 255
`endif

package pn_stage_ctrl_pkg;

  localparam int unsigned SWAP_CNT_W = 16;

  typedef enum logic {
    DIR_OLD_TO_OUT0 = 1'b0,
    DIR_OLD_TO_OUT1 = 1'b1
  } dir_e;

  function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
    return (v == {SWAP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pn_cmp.sv
// Effective-time mapping and swap decision for one 2-input sort stage.
// Purely combinational; the tie_used output tells the caller to toggle tie_flip.
module pn_cmp
  import pn_stage_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_TIME = `WIDTH_TIME,
  parameter int unsigned MAX_TIME   = `MAX_TIME
) (
  input  logic                  cfg_dir,
  input  logic                  tie_flip,
  input  logic                  in0_valid,
  input  logic [WIDTH_TIME-1:0] in0_time,
  input  logic                  in1_valid,
  input  logic [WIDTH_TIME-1:0] in1_time,
  output logic                  swap,
  output logic                  tie_used
);

  localparam logic [WIDTH_TIME-1:0] MAX_T = WIDTH_TIME'(MAX_TIME);

  logic [WIDTH_TIME-1:0] eff0;
  logic [WIDTH_TIME-1:0] eff1;
  logic                  both_live;
  dir_e                  dir;

  always_comb begin
    eff0      = (in0_valid && (in0_time != '0)) ? in0_time : MAX_T;
    eff1      = (in1_valid && (in1_time != '0)) ? in1_time : MAX_T;
    both_live = in0_valid && in1_valid && (in0_time != '0) && (in1_time != '0);
    dir       = dir_e'(cfg_dir);
    tie_used  = both_live && (eff0 == eff1);
    swap      = 1'b0;
    // Only genuine ties between two live flits alternate; other equalities stay put
    if (tie_used) begin
      swap = tie_flip;
    end else if (dir == DIR_OLD_TO_OUT0) begin
      swap = (eff1 < eff0);
    end else begin
      swap = (eff0 < eff1);
    end
  end

endmodule

// File: rtl/pn_stage_ctrl.sv
// One registered compare-exchange stage of a timestamp-ordering network.
// Inputs are sorted by age, registered with 1-cycle latency, and held under stall.
module pn_stage_ctrl
  import pn_stage_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_TIME = `WIDTH_TIME,
  parameter int unsigned WIDTH_DATA = 64,
  parameter int unsigned MAX_TIME   = `MAX_TIME
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_dir,
  input  logic                  in0_valid,
  input  logic [WIDTH_TIME-1:0] in0_time,
  input  logic [WIDTH_DATA-1:0] in0_data,
  input  logic                  in1_valid,
  input  logic [WIDTH_TIME-1:0] in1_time,
  input  logic [WIDTH_DATA-1:0] in1_data,
  output logic                  in_ready,
  input  logic                  out_stall,
  output logic                  out0_valid,
  output logic [WIDTH_TIME-1:0] out0_time,
  output logic [WIDTH_DATA-1:0] out0_data,
  output logic                  out1_valid,
  output logic [WIDTH_TIME-1:0] out1_time,
  output logic [WIDTH_DATA-1:0] out1_data,
  output logic                  out_swapped,
  output logic [15:0]           swap_count
);

  logic accept;
  logic swap;
  logic tie_used;

  logic                  out0_valid_q, out0_valid_d;
  logic [WIDTH_TIME-1:0] out0_time_q,  out0_time_d;
  logic [WIDTH_DATA-1:0] out0_data_q,  out0_data_d;
  logic                  out1_valid_q, out1_valid_d;
  logic [WIDTH_TIME-1:0] out1_time_q,  out1_time_d;
  logic [WIDTH_DATA-1:0] out1_data_q,  out1_data_d;
  logic                  swapped_q,    swapped_d;
  logic                  tie_flip_q,   tie_flip_d;
  logic [SWAP_CNT_W-1:0] swap_cnt_q,   swap_cnt_d;

  assign in_ready = ~out_stall;
  assign accept   = in_ready;

  pn_cmp #(
    .WIDTH_TIME (WIDTH_TIME),
    .MAX_TIME   (MAX_TIME)
  ) u_cmp (
    .cfg_dir   (cfg_dir),
    .tie_flip  (tie_flip_q),
    .in0_valid (in0_valid),
    .in0_time  (in0_time),
    .in1_valid (in1_valid),
    .in1_time  (in1_time),
    .swap      (swap),
    .tie_used  (tie_used)
  );

  always_comb begin
    out0_valid_d = out0_valid_q;
    out0_time_d  = out0_time_q;
    out0_data_d  = out0_data_q;
    out1_valid_d = out1_valid_q;
    out1_time_d  = out1_time_q;
    out1_data_d  = out1_data_q;
    swapped_d    = swapped_q;
    tie_flip_d   = tie_flip_q;
    swap_cnt_d   = swap_cnt_q;
    if (accept) begin
      out0_valid_d = swap ? in1_valid : in0_valid;
      out0_time_d  = swap ? in1_time  : in0_time;
      out0_data_d  = swap ? in1_data  : in0_data;
      out1_valid_d = swap ? in0_valid : in1_valid;
      out1_time_d  = swap ? in0_time  : in1_time;
      out1_data_d  = swap ? in0_data  : in1_data;
      swapped_d    = swap;
      tie_flip_d   = tie_flip_q ^ tie_used;
      // A swap of two bubbles carries no information and is not counted
      if (swap && (in0_valid || in1_valid)) begin
        swap_cnt_d = sat_inc(swap_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out0_valid_q <= 1'b0;
      out0_time_q  <= '0;
      out0_data_q  <= '0;
      out1_valid_q <= 1'b0;
      out1_time_q  <= '0;
      out1_data_q  <= '0;
      swapped_q    <= 1'b0;
      tie_flip_q   <= 1'b0;
      swap_cnt_q   <= '0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out0_time_q  <= out0_time_d;
      out0_data_q  <= out0_data_d;
      out1_valid_q <= out1_valid_d;
      out1_time_q  <= out1_time_d;
      out1_data_q  <= out1_data_d;
      swapped_q    <= swapped_d;
      tie_flip_q   <= tie_flip_d;
      swap_cnt_q   <= swap_cnt_d;
    end
  end

  assign out0_valid  = out0_valid_q;
  assign out0_time   = out0_time_q;
  assign out0_data   = out0_data_q;
  assign out1_valid  = out1_valid_q;
  assign out1_time   = out1_time_q;
  assign out1_data   = out1_data_q;
  assign out_swapped = swapped_q;
  assign swap_count  = swap_cnt_q;

endmodule

// File: tb/tb_pn_stage_ctrl.sv
// Bench for pn_stage_ctrl: directed vectors, an age-ordering reference model
// checked every cycle, and literal expectations for the key scenarios.
module tb_pn_stage_ctrl;

  localparam int WT = 8;
  localparam int WD = 64;
  localparam int MT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_dir;
  logic          in0_valid, in1_valid;
  logic [WT-1:0] in0_time, in1_time;
  logic [WD-1:0] in0_data, in1_data;
  logic          in_ready;
  logic          out_stall;
  logic          out0_valid, out1_valid;
  logic [WT-1:0] out0_time, out1_time;
  logic [WD-1:0] out0_data, out1_data;
  logic          out_swapped;
  logic [15:0]   swap_count;

  always #5 clk = ~clk;

  pn_stage_ctrl #(
    .WIDTH_TIME (WT),
    .WIDTH_DATA (WD),
    .MAX_TIME   (MT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_dir     (cfg_dir),
    .in0_valid   (in0_valid),
    .in0_time    (in0_time),
    .in0_data    (in0_data),
    .in1_valid   (in1_valid),
    .in1_time    (in1_time),
    .in1_data    (in1_data),
    .in_ready    (in_ready),
    .out_stall   (out_stall),
    .out0_valid  (out0_valid),
    .out0_time   (out0_time),
    .out0_data   (out0_data),
    .out1_valid  (out1_valid),
    .out1_time   (out1_time),
    .out1_data   (out1_data),
    .out_swapped (out_swapped),
    .swap_count  (swap_count)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: what the registered outputs must hold after each edge
  bit          model_on = 0;
  bit          m_zero;
  bit          m_v0, m_v1, m_sw, m_tie;
  int          m_t0, m_t1, m_cnt;
  logic [63:0] m_d0, m_d1;
  int          e0, e1;
  bit          is_tie, sw, older_is_in1;

  always @(posedge clk) begin
    if (reset) begin
      model_on = 1; m_zero = 1;
      m_v0 = 0; m_v1 = 0; m_t0 = 0; m_t1 = 0; m_d0 = '0; m_d1 = '0;
      m_sw = 0; m_tie = 0; m_cnt = 0;
    end else if (!out_stall) begin
      e0 = (in0_valid && in0_time != 0) ? int'(in0_time) : MT;
      e1 = (in1_valid && in1_time != 0) ? int'(in1_time) : MT;
      is_tie = in0_valid && in1_valid && in0_time != 0 && in1_time != 0 && e0 == e1;
      if (is_tie) begin
        sw = m_tie;
        m_tie = !m_tie;
      end else if (e0 == e1) begin
        sw = 0;
      end else begin
        older_is_in1 = (e1 < e0);
        sw = (cfg_dir == 1'b0) ? older_is_in1 : !older_is_in1;
      end
      m_v0 = sw ? in1_valid : in0_valid;
      m_v1 = sw ? in0_valid : in1_valid;
      m_t0 = sw ? int'(in1_time) : int'(in0_time);
      m_t1 = sw ? int'(in0_time) : int'(in1_time);
      m_d0 = sw ? in1_data : in0_data;
      m_d1 = sw ? in0_data : in1_data;
      m_sw = sw;
      if (sw && (in0_valid || in1_valid) && m_cnt < 65535) m_cnt++;
      m_zero = 0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      #1;
      chk("in_ready", 64'(in_ready), 64'(!out_stall));
      chk("out0_valid", 64'(out0_valid), 64'(m_v0));
      chk("out1_valid", 64'(out1_valid), 64'(m_v1));
      chk("out_swapped", 64'(out_swapped), 64'(m_sw));
      chk("swap_count", 64'(swap_count), 64'(m_cnt));
      if (m_v0 || m_zero) begin
        chk("out0_time", 64'(out0_time), 64'(m_t0));
        chk("out0_data", out0_data, m_d0);
      end
      if (m_v1 || m_zero) begin
        chk("out1_time", 64'(out1_time), 64'(m_t1));
        chk("out1_data", out1_data, m_d1);
      end
    end
  end

  task automatic drive(input bit rst, input bit st, input bit dir,
                       input bit v0, input logic [7:0] t0, input logic [63:0] d0,
                       input bit v1, input logic [7:0] t1, input logic [63:0] d1);
    @(negedge clk);
    reset = rst; out_stall = st; cfg_dir = dir;
    in0_valid = v0; in0_time = t0; in0_data = d0;
    in1_valid = v1; in1_time = t1; in1_data = d1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1; out_stall = 0; cfg_dir = 0;
    in0_valid = 1; in0_time = 8'd7; in0_data = 64'hDEAD;
    in1_valid = 1; in1_time = 8'd3; in1_data = 64'hBEEF;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out0_valid", 64'(out0_valid), 64'd0);
    chk("rst_out1_time", 64'(out1_time), 64'd0);
    chk("rst_out0_data", out0_data, 64'd0);
    chk("rst_swapped", 64'(out_swapped), 64'd0);
    chk("rst_count", 64'(swap_count), 64'd0);

    // older flit to out0
    drive(0, 0, 0, 1, 8'd9, 64'hA9, 1, 8'd4, 64'hB4);
    settle();
    chk("v033_out0_t", 64'(out0_time), 64'd4);
    chk("v033_out1_t", 64'(out1_time), 64'd9);
    chk("v033_out0_d", out0_data, 64'hB4);
    chk("v033_swapped", 64'(out_swapped), 64'd1);
    chk("v033_count", 64'(swap_count), 64'd1);

    drive(0, 0, 1, 1, 8'd3, 64'hA3, 1, 8'd7, 64'hB7);
    settle();
    chk("dir1_out0_t", 64'(out0_time), 64'd7);
    chk("dir1_out1_t", 64'(out1_time), 64'd3);
    chk("dir1_swapped", 64'(out_swapped), 64'd1);

    drive(0, 0, 0, 1, 8'd0, 64'hA0, 1, 8'd7, 64'hB7);
    settle();
    chk("t0_out0_t", 64'(out0_time), 64'd7);
    chk("t0_swapped", 64'(out_swapped), 64'd1);
    chk("t0_count", 64'(swap_count), 64'd3);

    // ties alternate
    drive(0, 0, 0, 1, 8'd5, 64'h51, 1, 8'd5, 64'h52);
    settle();
    chk("tie1_swapped", 64'(out_swapped), 64'd0);
    drive(0, 0, 0, 1, 8'd5, 64'h53, 1, 8'd5, 64'h54);
    settle();
    chk("tie2_swapped", 64'(out_swapped), 64'd1);
    chk("tie2_out0_d", out0_data, 64'h54);
    drive(0, 0, 0, 1, 8'd5, 64'h55, 1, 8'd5, 64'h56);
    settle();
    chk("tie3_swapped", 64'(out_swapped), 64'd0);
    chk("tie3_count", 64'(swap_count), 64'd4);
    drive(0, 0, 0, 1, 8'd5, 64'h57, 1, 8'd5, 64'h58);
    settle();
    chk("tie4_swapped", 64'(out_swapped), 64'd1);

    // invalid inputs
    drive(0, 0, 0, 0, 8'd2, 64'h11, 1, 8'd6, 64'h16);
    settle();
    chk("inv_out0_valid", 64'(out0_valid), 64'd1);
    chk("inv_out0_t", 64'(out0_time), 64'd6);
    chk("inv_out1_valid", 64'(out1_valid), 64'd0);
    chk("inv_count", 64'(swap_count), 64'd6);
    drive(0, 0, 0, 0, 8'd9, 64'h21, 0, 8'd4, 64'h22);
    settle();
    chk("bub_out0_valid", 64'(out0_valid), 64'd0);
    chk("bub_out1_valid", 64'(out1_valid), 64'd0);
    chk("bub_count", 64'(swap_count), 64'd6);

    // stall holds everything, including tie state and cfg_dir effects
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, i[0], 1, 8'(5 + i), 64'(i), 1, 8'(5 + i), 64'(100 + i));
      settle();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out0_valid", 64'(out0_valid), 64'd0);
      chk("stall_count", 64'(swap_count), 64'd6);
    end
    drive(0, 0, 0, 1, 8'd5, 64'h61, 1, 8'd5, 64'h62);
    settle();
    chk("rel_out0_t", 64'(out0_time), 64'd5);
    chk("rel_out0_d", out0_data, 64'h61);
    chk("rel_swapped", 64'(out_swapped), 64'd0);
    drive(0, 0, 0, 1, 8'd5, 64'h63, 1, 8'd5, 64'h64);
    settle();
    chk("rel2_swapped", 64'(out_swapped), 64'd1);
    chk("rel2_count", 64'(swap_count), 64'd7);

    // equal effective times that are not live ties never swap
    drive(0, 0, 0, 1, 8'd255, 64'h71, 0, 8'd3, 64'h72);
    settle();
    chk("max_swapped", 64'(out_swapped), 64'd0);
    chk("max_out0_t", 64'(out0_time), 64'd255);
    drive(0, 0, 1, 1, 8'd0, 64'h81, 1, 8'd255, 64'h82);
    settle();
    chk("zero_vs_max_swapped", 64'(out_swapped), 64'd0);

    // saturation
    for (int i = 0; i < 65540; i++) begin
      drive(0, 0, 0, 1, 8'd9, 64'(i), 1, 8'd4, 64'(~i));
    end
    settle();
    chk("sat_count", 64'(swap_count), 64'hFFFF);

    // reset wins over stall
    drive(1, 1, 0, 1, 8'd9, 64'h91, 1, 8'd4, 64'h92);
    settle();
    chk("rst2_in_ready", 64'(in_ready), 64'd0);
    chk("rst2_out0_valid", 64'(out0_valid), 64'd0);
    chk("rst2_out1_time", 64'(out1_time), 64'd0);
    chk("rst2_out0_data", out0_data, 64'd0);
    chk("rst2_swapped", 64'(out_swapped), 64'd0);
    chk("rst2_count", 64'(swap_count), 64'd0);
    drive(0, 0, 0, 1, 8'd2, 64'hC2, 1, 8'd3, 64'hC3);
    settle();
    chk("post_out0_t", 64'(out0_time), 64'd2);
    chk("post_swapped", 64'(out_swapped), 64'd0);

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pn_stage_ctrl.md
PN_STAGE_CTRL -- requirements
Module: pn_stage_ctrl

Interface
REQ-001 Parameter WIDTH_TIME, default `WIDTH_TIME (global), timestamp width; smaller nonzero value = older flit.
REQ-002 Parameter WIDTH_DATA, default 64, flit payload width excluding timestamp.
REQ-003 Parameter MAX_TIME, default `MAX_TIME (global), effective time used for timestamp 0 or invalid flit.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_dir  in  1  sort direction: 0 = older flit to out0, 1 = older flit to out1.
REQ-007 in0_valid / in1_valid  in  1 each  input flit present.
REQ-008 in0_time / in1_time  in  WIDTH_TIME each  input timestamp.
REQ-009 in0_data / in1_data  in  WIDTH_DATA each  input payload.
REQ-010 in_ready  out  1  stage accepts inputs this cycle.
REQ-011 out_stall  in  1  downstream cannot accept; hold outputs.
REQ-012 out0_valid/time/data, out1_valid/time/data  out  1/WIDTH_TIME/WIDTH_DATA  registered sorted flits.
REQ-013 out_swapped  out  1  registered flag: current outputs were crossed.
REQ-014 swap_count  out  16  saturating count of swaps performed.

Function
REQ-015 Effective time per input SHALL be MAX_TIME if valid=0 or time=0, else the time value.
REQ-016 Swap decision SHALL be: cfg_dir=0 -> swap iff eff1 < eff0; cfg_dir=1 -> swap iff eff0 < eff1; strict compare, unsigned.
REQ-017 On equal effective times with both valid=1 and both time nonzero, swap SHALL equal tie_flip register value; otherwise ties never swap.
REQ-018 tie_flip SHALL toggle on every accepted cycle where REQ-017 tie rule was applied; unchanged otherwise.
REQ-019 in_ready SHALL equal NOT out_stall (combinational); accept = in_ready.
REQ-020 On accept, output registers SHALL load (swap ? in1 : in0) into out0 and (swap ? in0 : in1) into out1, valid/time/data moving together; latency exactly 1 cycle.
REQ-021 On accept with both in valid=0, output valids SHALL load 0 (bubble); data/time don't-care.
REQ-022 While out_stall=1, all output registers, tie_flip and swap_count SHALL hold.
REQ-023 out_swapped SHALL load the swap decision on accept.
REQ-024 swap_count SHALL increment by 1 on accept with swap=1 and at least one valid input, saturating at 16'hFFFF.
REQ-025 cfg_dir SHALL be sampled only in the accepting cycle; change while stalled affects no held output.
REQ-026 Swap decision logic SHALL be a single-cycle combinational path; no multi-cycle sequencing.

Reset
REQ-027 With reset=1 at a clock edge: out0_valid=0, out1_valid=0, out times=0, out data=0, out_swapped=0, tie_flip=0, swap_count=0.
REQ-028 Reset SHALL take priority over accept and stall; inputs in the reset cycle are dropped.
REQ-029 in_ready SHALL follow REQ-019 during reset (no reset gating).

Structure
REQ-030 WIDTH_TIME and MAX_TIME SHALL come from global.v; no local redefinition of defaults.
REQ-031 Comparison + effective-time mapping SHALL be one sub-module, pn_cmp (inputs: eff times, cfg_dir, tie_flip, both-valid; output: swap); datapath, counters, registers in pn_stage_ctrl.
REQ-032 No other sub-modules; target 120-250 lines RTL.

Verification (WIDTH_TIME=8, MAX_TIME=255)
REQ-033 cfg_dir=0, in0 (v=1,t=9), in1 (v=1,t=4), no stall -> next cycle out0.t=4, out1.t=9, out_swapped=1, swap_count=1.
REQ-034 cfg_dir=1, in0 t=3, in1 t=7 -> out0.t=7, out1.t=3, swapped=1; in0 t=0 (v=1), in1 t=7 -> swap under cfg_dir=0 (eff 255 vs 7), out0.t=7.
REQ-035 Tie: both valid t=5 for 3 consecutive accepts -> out_swapped 0,1,0; tie_flip ends 1; swap_count +1.
REQ-036 in0 v=0, in1 v=1 t=6, cfg_dir=0 -> out0 valid=1 t=6, out1 valid=0; both invalid -> both out valids 0, swap_count unchanged.
REQ-037 out_stall=1 for 4 cycles with changing inputs -> in_ready=0, outputs/swap_count/tie_flip unchanged; release -> next input loads after 1 cycle.
REQ-038 swap_count preset via 65535 swaps -> stays 16'hFFFF; reset asserted mid-stream with stall=1 -> all outputs zero next edge.
